// File: rtl/mult_div_seq.sv
// Sequential signed 32x32 multiply (radix-2 Booth) and divide (restoring) unit.
// One iteration per cycle; HI/LO results are registered on entry to DONE.
module mult_div_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   output logic        busy,
   output logic        done,
   output logic        div_zero,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic        hi_write,
   output logic        lo_write
);

   typedef enum logic [2:0] {StIdle, StMult, StDiv, StFix, StDone} state_e;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] acc_q, acc_d;     // Booth accumulator / division remainder
   logic [31:0] mq_q, mq_d;       // multiplier / dividend-then-quotient
   logic        q1_q, q1_d;       // Booth q-1 bit
   logic [31:0] opnd_q, opnd_d;   // multiplicand / divisor magnitude
   logic        neg_quo_q, neg_quo_d;
   logic        neg_rem_q, neg_rem_d;
   logic        dz_q, dz_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic [32:0] sum;
   logic [32:0] shifted;
   logic        use_sub;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               if (!op) begin
                  state_d = StMult;
               end else if (b_in == 32'd0) begin
                  state_d = StDone;
               end else begin
                  state_d = StDiv;
               end
            end
         end
         StMult:  if (cnt_q == 6'd31) state_d = StDone;
         StDiv:   if (cnt_q == 6'd31) state_d = StFix;
         StFix:   state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      busy     = 1'b0;
      done     = 1'b0;
      div_zero = 1'b0;
      hi_write = 1'b0;
      lo_write = 1'b0;
      case (state_q)
         StMult, StDiv, StFix: busy = 1'b1;
         StDone: begin
            done     = 1'b1;
            div_zero = dz_q;
            hi_write = ~dz_q;
            lo_write = ~dz_q;
         end
         default: ;
      endcase
   end

   // Datapath next-state
   always_comb begin
      acc_d     = acc_q;
      mq_d      = mq_q;
      q1_d      = q1_q;
      opnd_d    = opnd_q;
      cnt_d     = cnt_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      sum       = '0;
      shifted   = '0;
      use_sub   = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               cnt_d     = 6'd0;
               acc_d     = 32'd0;
               q1_d      = 1'b0;
               dz_d      = op & (b_in == 32'd0);
               neg_quo_d = a_in[31] ^ b_in[31];
               neg_rem_d = a_in[31];
               if (!op) begin
                  opnd_d = a_in;
                  mq_d   = b_in;
               end else begin
                  opnd_d = b_in[31] ? -b_in : b_in;
                  mq_d   = a_in[31] ? -a_in : a_in;
               end
            end
         end
         StMult: begin
            // 33-bit add keeps the most-negative multiplicand exact before the shift
            unique case ({mq_q[0], q1_q})
               2'b01:   sum = {acc_q[31], acc_q} + {opnd_q[31], opnd_q};
               2'b10:   sum = {acc_q[31], acc_q} - {opnd_q[31], opnd_q};
               default: sum = {acc_q[31], acc_q};
            endcase
            acc_d = sum[32:1];
            mq_d  = {sum[0], mq_q[31:1]};
            q1_d  = mq_q[0];
            cnt_d = cnt_q + 6'd1;
         end
         StDiv: begin
            shifted = {acc_q, mq_q[31]};
            use_sub = (shifted >= {1'b0, opnd_q});
            // Remainder stays below the divisor, so the low 32 bits are exact
            acc_d   = use_sub ? (shifted[31:0] - opnd_q) : shifted[31:0];
            mq_d    = {mq_q[30:0], use_sub};
            cnt_d   = cnt_q + 6'd1;
         end
         StFix: begin
            mq_d  = neg_quo_q ? -mq_q : mq_q;
            acc_d = neg_rem_q ? -acc_q : acc_q;
         end
         default: ;
      endcase
   end

   // Results captured only when a real operation completes
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (state_d == StDone && (state_q == StMult || state_q == StFix)) begin
         hi_d = acc_d;
         lo_d = mq_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= 6'd0;
         acc_q     <= 32'd0;
         mq_q      <= 32'd0;
         q1_q      <= 1'b0;
         opnd_q    <= 32'd0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         mq_q      <= mq_d;
         q1_q      <= q1_d;
         opnd_q    <= opnd_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign hi_out = hi_q;
   assign lo_out = lo_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed self-checking bench for mult_div_seq: vector table of signed MULT/DIV
// cases plus hand sequences for reset, start re-pulse and abort.
module tb_mult_div_seq;

   logic        clk = 1'b0;
   logic        reset, start, op;
   logic [31:0] a_in, b_in;
   logic        busy, done, div_zero, hi_write, lo_write;
   logic [31:0] hi_out, lo_out;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string       name;
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          lat;
   } vec_t;

   vec_t vecs[17];

   mult_div_seq dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a_in     (a_in),
      .b_in     (b_in),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi_out   (hi_out),
      .lo_out   (lo_out),
      .hi_write (hi_write),
      .lo_write (lo_write)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one operation and check latency and results at the done pulse.
   // repulse != 0 re-asserts start with other operands in that busy cycle.
   task automatic run_op(input string name, input logic o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input logic exp_dz, input int lat,
                         input int repulse);
      bit found;
      int c;
      @(negedge clk);
      check({name, "/idle_done"}, {31'b0, done}, 32'd0);
      start = 1'b1;
      op    = o;
      a_in  = a;
      b_in  = b;
      @(posedge clk);
      found = 0;
      c     = 0;
      while (!found && c < 60) begin
         @(negedge clk);
         c++;
         if (c == 1) begin
            start = 1'b0;
            op    = ~o;
            a_in  = ~a;
            b_in  = 32'd0;
            if (lat > 1) check({name, "/busy"}, {31'b0, busy}, 32'd1);
         end
         if (repulse != 0 && c == repulse) begin
            start = 1'b1;
            op    = 1'b1;
            a_in  = 32'h0000_0005;
            b_in  = 32'h0000_0000;
         end
         if (repulse != 0 && c == repulse + 1) start = 1'b0;
         if (done) begin
            found = 1;
            check({name, "/latency"}, 32'(c), 32'(lat));
            check({name, "/hi"}, hi_out, exp_hi);
            check({name, "/lo"}, lo_out, exp_lo);
            check({name, "/div_zero"}, {31'b0, div_zero}, {31'b0, exp_dz});
            check({name, "/hi_write"}, {31'b0, hi_write}, {31'b0, ~exp_dz});
            check({name, "/lo_write"}, {31'b0, lo_write}, {31'b0, ~exp_dz});
            check({name, "/busy_at_done"}, {31'b0, busy}, 32'd0);
         end
      end
      if (!found) check({name, "/timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      int c;
      int done_cnt;

      vecs[0]  = '{"mul_7_m3",     1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33};
      vecs[1]  = '{"mul_min_min",  1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33};
      vecs[2]  = '{"mul_shift",    1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, 33};
      vecs[3]  = '{"mul_m1_m1",    1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 33};
      vecs[4]  = '{"mul_max_max",  1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 33};
      vecs[5]  = '{"mul_min_1",    1'b0, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33};
      vecs[6]  = '{"mul_zero",     1'b0, 32'h0000_0000, 32'h0000_1234, 32'h0000_0000, 32'h0000_0000, 1'b0, 33};
      vecs[7]  = '{"div_m7_2",     1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
      vecs[8]  = '{"div_ovf",      1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34};
      vecs[9]  = '{"div_100_7",    1'b1, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0, 34};
      vecs[10] = '{"div_7_m2",     1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 34};
      vecs[11] = '{"div_m7_m2",    1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 34};
      vecs[12] = '{"div_5_9",      1'b1, 32'h0000_0005, 32'h0000_0009, 32'h0000_0005, 32'h0000_0000, 1'b0, 34};
      vecs[13] = '{"div_m1_min",   1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 34};
      vecs[14] = '{"div_m1_1",     1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 34};
      vecs[15] = '{"div_set_1122", 1'b1, 32'h0000_0451, 32'h0000_0020, 32'h0000_0011, 32'h0000_0022, 1'b0, 34};
      vecs[16] = '{"div_by_zero",  1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0011, 32'h0000_0022, 1'b1, 1};

      // Reset with start held high: reset must win.
      reset = 1'b1;
      start = 1'b1;
      op    = 1'b0;
      a_in  = 32'h3;
      b_in  = 32'h4;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      check("rst/busy", {31'b0, busy}, 32'd0);
      check("rst/done", {31'b0, done}, 32'd0);
      check("rst/div_zero", {31'b0, div_zero}, 32'd0);
      check("rst/hi_write", {31'b0, hi_write}, 32'd0);
      check("rst/lo_write", {31'b0, lo_write}, 32'd0);
      check("rst/hi", hi_out, 32'd0);
      check("rst/lo", lo_out, 32'd0);
      @(negedge clk);
      check("rst_prio/busy", {31'b0, busy}, 32'd0);

      foreach (vecs[i]) begin
         run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                vecs[i].dz, vecs[i].lat, 0);
      end

      run_op("repulse", 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB,
             1'b0, 33, 5);

      // Abort a MULT with reset in cycle 10.
      @(negedge clk);
      start = 1'b1;
      op    = 1'b0;
      a_in  = 32'h0000_0003;
      b_in  = 32'h0000_0005;
      @(posedge clk);
      for (c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (c == 10) reset = 1'b1;
      end
      @(negedge clk);
      reset = 1'b0;
      check("abort/busy", {31'b0, busy}, 32'd0);
      check("abort/done", {31'b0, done}, 32'd0);
      check("abort/div_zero", {31'b0, div_zero}, 32'd0);
      check("abort/hi_write", {31'b0, hi_write}, 32'd0);
      check("abort/lo_write", {31'b0, lo_write}, 32'd0);
      check("abort/hi", hi_out, 32'd0);
      check("abort/lo", lo_out, 32'd0);
      done_cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      check("abort/no_done", 32'(done_cnt), 32'd0);

      run_op("after_abort", 1'b0, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000,
             32'h0000_000F, 1'b0, 33, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
